uart_rx_fifo_ctrl: RTL and testbench

Sequencing and status controller for the UART receiver FIFO (16 x 10-bit words, `{data[7:0], pe, fe}`).
- Accepts characters from the receiver shift logic and issues FIFO push/pop strobes.
- Tracks a live count of error-flagged words for LSR bit 7.
- Generates the received-data-available (trigger level) and character-timeout interrupts.
- Sits between the RX shifter, the RX FIFO and the register/interrupt block.

---
 rtl/uart_rx_fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver FIFO controller: push/pop sequencing, LSR status and RX interrupts.
// Define UART_RX_TOUT_EN to build the character-timeout counter and int_tout.
module uart_rx_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int CT_W       = 12
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_pe,
  input  logic             rx_fe,
  output logic             fifo_push,
  output logic [9:0]       fifo_din,
  output logic             fifo_pop,
  output logic             fifo_rst,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic [9:0]       fifo_dout,
  input  logic             fifo_en,
  input  logic             rx_clr,
  input  logic [1:0]       trig_lvl,
  input  logic [CT_W-1:0]  char_time,
  input  logic             rbr_rd,
  input  logic             lsr_rd,
  output logic [7:0]       rbr_data,
  output logic             lsr_dr,
  output logic             lsr_oe,
  output logic             lsr_pe,
  output logic             lsr_fe,
  output logic             lsr_err,
  output logic             int_rda,
  output logic             int_tout
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} pop_state_e;

  pop_state_e       state_q, state_d;
  logic             lsr_oe_q, lsr_oe_d;
  logic             int_rda_q, int_rda_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fifo_en_q, fifo_en_d;

  logic             clr, pop_now, push_ok, push_now, overrun, push_err, pop_err;
  logic [CNT_W-1:0] cap, trig;

  always_comb begin
    cap  = fifo_en ? CNT_W'(FIFO_DEPTH) : CNT_W'(1);
    trig = CNT_W'(14);
    case (trig_lvl)
      2'b00:   trig = CNT_W'(1);
      2'b01:   trig = CNT_W'(4);
      2'b10:   trig = CNT_W'(8);
      default: trig = CNT_W'(14);
    endcase
  end

  // A mode change empties the FIFO exactly like an explicit rx_clr.
  always_comb begin
    clr      = rx_clr | (fifo_en != fifo_en_q);
    pop_now  = (state_q == POP) & wb_rst_i & ~clr;
    push_ok  = (fifo_count < cap) | ((fifo_count == cap) & pop_now);
    push_now = rx_valid & push_ok & wb_rst_i & ~clr;
    overrun  = rx_valid & ~push_ok & ~clr;
    push_err = push_now & (rx_pe | rx_fe);
    pop_err  = pop_now & (fifo_dout[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rbr_rd && fifo_count != '0) state_d = POP;
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;

    lsr_oe_d = lsr_oe_q;
    if (overrun)     lsr_oe_d = 1'b1;
    else if (lsr_rd) lsr_oe_d = 1'b0;

    err_cnt_d = err_cnt_q;
    if (clr)
      err_cnt_d = '0;
    else if (push_err && !pop_err && err_cnt_q != CNT_W'(FIFO_DEPTH))
      err_cnt_d = err_cnt_q + CNT_W'(1);
    else if (pop_err && !push_err && err_cnt_q != '0)
      err_cnt_d = err_cnt_q - CNT_W'(1);

    int_rda_d = fifo_en ? (fifo_count >= trig) : (fifo_count != '0);
    fifo_en_d = fifo_en;
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      lsr_oe_q  <= 1'b0;
      int_rda_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lsr_oe_q  <= lsr_oe_d;
      int_rda_q <= int_rda_d;
      err_cnt_q <= err_cnt_d;
    end
    fifo_en_q <= fifo_en_d;
  end

`ifdef UART_RX_TOUT_EN
  logic [CT_W+1:0] tout_q, tout_d, tout_lim;

  // Idle time since the last FIFO activity, saturating at four character times.
  always_comb begin
    tout_lim = {char_time, 2'b00};
    tout_d   = tout_q;
    if (clr || push_now || pop_now || fifo_count == '0)
      tout_d = '0;
    else if (tout_q < tout_lim)
      tout_d = tout_q + (CT_W+2)'(1);
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i) tout_q <= '0;
    else           tout_q <= tout_d;
  end

  assign int_tout = (tout_q == tout_lim) & (fifo_count != '0) & fifo_en & (char_time != '0);
`else
  logic unused_char_time;
  assign unused_char_time = ^char_time;
  assign int_tout         = 1'b0;
`endif

  assign fifo_push = push_now;
  assign fifo_din  = {rx_data, rx_pe, rx_fe};
  assign fifo_pop  = pop_now;
  assign fifo_rst  = ~wb_rst_i | clr;
  assign rbr_data  = fifo_dout[9:2];
  assign lsr_dr    = (fifo_count != '0);
  assign lsr_pe    = lsr_dr & fifo_dout[1];
  assign lsr_fe    = lsr_dr & fifo_dout[0];
  assign lsr_oe    = lsr_oe_q;
  assign lsr_err   = (err_cnt_q != '0);
  assign int_rda   = int_rda_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl: a queue-based FIFO environment plus a
// queue-based reference model; expectations are queued per cycle and checked at negedge.
`timescale 1ns/1ps
module tb_uart_rx_fifo_ctrl;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;
  localparam int CT_W       = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             wb_rst_i = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data  = '0;
  logic             rx_pe    = 1'b0;
  logic             rx_fe    = 1'b0;
  logic             fifo_push;
  logic [9:0]       fifo_din;
  logic             fifo_pop;
  logic             fifo_rst;
  logic [CNT_W-1:0] fifo_count = '0;
  logic [9:0]       fifo_dout  = '0;
  logic             fifo_en   = 1'b0;
  logic             rx_clr    = 1'b0;
  logic [1:0]       trig_lvl  = '0;
  logic [CT_W-1:0]  char_time = '0;
  logic             rbr_rd    = 1'b0;
  logic             lsr_rd    = 1'b0;
  logic [7:0]       rbr_data;
  logic             lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_err, int_rda, int_tout;

  uart_rx_fifo_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .CT_W(CT_W)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pe(rx_pe), .rx_fe(rx_fe), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .fifo_pop(fifo_pop), .fifo_rst(fifo_rst), .fifo_count(fifo_count),
    .fifo_dout(fifo_dout), .fifo_en(fifo_en), .rx_clr(rx_clr), .trig_lvl(trig_lvl),
    .char_time(char_time), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd), .rbr_data(rbr_data),
    .lsr_dr(lsr_dr), .lsr_oe(lsr_oe), .lsr_pe(lsr_pe), .lsr_fe(lsr_fe),
    .lsr_err(lsr_err), .int_rda(int_rda), .int_tout(int_tout)
  );

  // Physical FIFO driven by the DUT strobes.
  logic [9:0] env_q[$];
  always @(posedge clk) begin
    if (fifo_rst) env_q.delete();
    else begin
      if (fifo_pop && env_q.size() > 0) env_q.delete(0);
      if (fifo_push && env_q.size() < FIFO_DEPTH) env_q.push_back(fifo_din);
    end
    fifo_count <= CNT_W'(env_q.size());
    fifo_dout  <= (env_q.size() > 0) ? env_q[0] : 10'd0;
  end

  typedef struct {
    logic       push;
    logic [9:0] din;
    logic       pop;
    logic       rst;
    logic       oe;
    logic       rda;
    logic       err;
    logic       dr;
    logic [9:0] head;
    logic       tout;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   running = 1'b0;

  // Reference model: word queue, overrun flag, read-busy countdown, idle age.
  logic [9:0] m_q[$];
  logic       m_oe = 1'b0, m_rda = 1'b0, m_prev_en = 1'b0;
  int         m_busy = 0, m_age = 0;
  logic       cfg_en = 1'b1;
  logic [1:0] cfg_trig = 2'b01;
  logic [CT_W-1:0] cfg_ct = 12'd10;

  function automatic int trigValue(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic valid, input logic [7:0] data,
                               input logic pe, input logic fe, input logic rd,
                               input logic lrd, input logic clr);
    exp_t e;
    int   cnt, cap, lim;
    logic clear, pop_now, accept, ovr;
    @(posedge clk);
    #1;
    wb_rst_i = rst_n;  rx_valid = valid;  rx_data = data;  rx_pe = pe;  rx_fe = fe;
    rbr_rd   = rd;     lsr_rd   = lrd;    rx_clr  = clr;
    fifo_en  = cfg_en; trig_lvl = cfg_trig; char_time = cfg_ct;

    cnt     = m_q.size();
    clear   = !rst_n || clr || (cfg_en != m_prev_en);
    cap     = cfg_en ? FIFO_DEPTH : 1;
    pop_now = (m_busy == 2) && !clear;
    accept  = valid && !clear && (cnt < cap || (cnt == cap && pop_now));
    ovr     = valid && !clear && !accept;
    lim     = 4 * int'(cfg_ct);

    e.push = accept;
    e.din  = {data, pe, fe};
    e.pop  = pop_now;
    e.rst  = clear;
    e.oe   = m_oe;
    e.rda  = m_rda;
    e.err  = 1'b0;
    foreach (m_q[i]) if (m_q[i][1:0] != 2'b00) e.err = 1'b1;
    e.dr   = (cnt != 0);
    e.head = (cnt != 0) ? m_q[0] : 10'd0;
`ifdef UART_RX_TOUT_EN
    e.tout = (m_age == lim) && (cnt != 0) && cfg_en && (cfg_ct != 0);
`else
    e.tout = 1'b0;
`endif
    exp_q.push_back(e);

    if (!rst_n)   m_oe = 1'b0;
    else if (ovr) m_oe = 1'b1;
    else if (lrd) m_oe = 1'b0;
    m_rda = rst_n && (cfg_en ? (cnt >= trigValue(cfg_trig)) : (cnt != 0));
    if (clear || accept || pop_now || cnt == 0) m_age = 0;
    else if (m_age < lim) m_age++;
    if (clear) begin
      m_q.delete();
      m_busy = 0;
    end else begin
      if (pop_now) m_q.delete(0);
      if (accept)  m_q.push_back({data, pe, fe});
      if (m_busy > 0)          m_busy--;
      else if (rd && cnt != 0) m_busy = 2;
    end
    m_prev_en = cfg_en;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushChar(input logic [7:0] d, input logic pe, input logic fe);
    applyStimulus(1'b1, 1'b1, d, pe, fe, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readRbr();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clearFifo();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic randomPhase(input int cycles, input int p_valid, input int p_rd, input int p_err);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(99) < 2) cfg_trig = 2'($urandom_range(3));
      applyStimulus($urandom_range(199) != 0,
                    $urandom_range(99) < p_valid,
                    8'($urandom_range(255)),
                    $urandom_range(99) < p_err,
                    $urandom_range(99) < p_err,
                    $urandom_range(99) < p_rd,
                    $urandom_range(99) < 10,
                    $urandom_range(99) < 2);
    end
  endtask

  always @(negedge clk) begin
    exp_t cur;
    if (running) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("fifo_push", 32'(fifo_push), 32'(cur.push));
        if (cur.push) checkOutput("fifo_din", 32'(fifo_din), 32'(cur.din));
        checkOutput("fifo_pop", 32'(fifo_pop), 32'(cur.pop));
        checkOutput("fifo_rst", 32'(fifo_rst), 32'(cur.rst));
        checkOutput("lsr_oe", 32'(lsr_oe), 32'(cur.oe));
        checkOutput("int_rda", 32'(int_rda), 32'(cur.rda));
        checkOutput("lsr_err", 32'(lsr_err), 32'(cur.err));
        checkOutput("lsr_dr", 32'(lsr_dr), 32'(cur.dr));
        checkOutput("rbr_data", 32'(rbr_data), 32'(cur.head[9:2]));
        checkOutput("lsr_pe", 32'(lsr_pe), 32'(cur.dr & cur.head[1]));
        checkOutput("lsr_fe", 32'(lsr_fe), 32'(cur.dr & cur.head[0]));
        checkOutput("int_tout", 32'(int_tout), 32'(cur.tout));
      end
    end
  end

  initial begin
    running = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Trigger level 4: int_rda after the 4th push, drops after one read
    for (int i = 0; i < 4; i++) begin
      pushChar(8'h41 + 8'(i), 1'b0, 1'b0);
      idle(1);
    end
    idle(2);
    readRbr();
    idle(4);

    // Fill to 16, overrun on the 17th, then clear it via lsr_rd
    clearFifo();
    for (int i = 0; i < 17; i++) pushChar(8'(8'h80 + i), 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Full FIFO: push in the POP cycle is accepted
    readRbr();
    pushChar(8'hC3, 1'b0, 1'b0);
    idle(3);

    // Error count tracks flagged words through reads
    clearFifo();
    pushChar(8'h11, 1'b0, 1'b0);
    pushChar(8'h22, 1'b1, 1'b0);
    pushChar(8'h33, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      readRbr();
      idle(3);
    end

    // Character timeout with char_time=10
    clearFifo();
    cfg_ct = 12'd10;
    pushChar(8'h5A, 1'b0, 1'b1);
    idle(45);
    readRbr();
    idle(3);

    // Reset asserted in the POP cycle
    pushChar(8'h01, 1'b0, 1'b0);
    pushChar(8'h02, 1'b0, 1'b0);
    readRbr();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic across modes and trigger levels
    cfg_ct = 12'd3;
    randomPhase(300, 50, 20, 15);
    randomPhase(200, 85, 5, 20);
    cfg_en = 1'b0;
    randomPhase(150, 40, 25, 20);
    cfg_en = 1'b1;
    cfg_ct = 12'd0;
    randomPhase(150, 30, 10, 20);
    cfg_ct = 12'd2;
    randomPhase(200, 20, 5, 20);

    @(negedge clk);
    #1;
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
